// File: rtl/cpu_isa_pkg.sv
// ============================================================================
// cpu_isa_pkg : opcode constants, field positions and decode classes
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    localparam int F_OP_HI  = 31;
    localparam int F_OP_LO  = 26;
    localparam int F_RS_HI  = 25;
    localparam int F_RS_LO  = 21;
    localparam int F_RT_HI  = 20;
    localparam int F_RT_LO  = 16;
    localparam int F_RD_HI  = 15;
    localparam int F_RD_LO  = 11;
    localparam int F_SH_HI  = 10;
    localparam int F_SH_LO  = 6;
    localparam int F_FN_HI  = 5;
    localparam int F_FN_LO  = 0;
    localparam int F_IMM_HI = 15;
    localparam int F_IMM_LO = 0;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_IMM  = 3'd1,
        CLS_LUI  = 3'd2,
        CLS_STBR = 3'd3,
        CLS_NOP  = 3'd4
    } decode_cls_e;

    function automatic decode_cls_e decode_class(input logic [5:0] op);
        decode_cls_e cls;
        case (op)
            OP_RTYPE:                                 cls = CLS_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: cls = CLS_IMM;
            OP_LUI:                                   cls = CLS_LUI;
            OP_SW, OP_BEQ, OP_BNE:                    cls = CLS_STBR;
            default:                                  cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_issue_stage_if.sv
// ============================================================================
// id_issue_stage_if : fetch, ALU-bundle and writeback signals of the issue stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface id_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();

    logic              IF_VALID;
    logic [31:0]       IF_INSTR;
    logic              IF_READY;
    logic              EX_VALID;
    logic              EX_READY;
    logic              FLUSH;
    logic [5:0]        OPCODE;
    logic [DATA_W-1:0] RS_VAL;
    logic [DATA_W-1:0] RT_VAL;
    logic [4:0]        SHAMT;
    logic [5:0]        FUNC;
    logic [15:0]       RAW_VAL;
    logic              DEST_EN;
    logic [REG_AW-1:0] DEST_ADDR;
    logic              WB_EN;
    logic [REG_AW-1:0] WB_ADDR;
    logic [DATA_W-1:0] WB_DATA;

    // Environment side: fetch, ALU and writeback source.
    modport master (
        output IF_VALID, IF_INSTR, EX_READY, FLUSH, WB_EN, WB_ADDR, WB_DATA,
        input  IF_READY, EX_VALID, OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC,
               RAW_VAL, DEST_EN, DEST_ADDR
    );

    modport slave (
        input  IF_VALID, IF_INSTR, EX_READY, FLUSH, WB_EN, WB_ADDR, WB_DATA,
        output IF_READY, EX_VALID, OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC,
               RAW_VAL, DEST_EN, DEST_ADDR
    );

endinterface

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// id_regfile : 2R/1W register file, same-cycle writeback bypass, r0 = 0
// Rev 1.0
// ============================================================================
`default_nettype none

module id_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    input  wire logic [REG_AW-1:0] i_rd_addr_a,
    output logic      [DATA_W-1:0] o_rd_data_a,
    input  wire logic [REG_AW-1:0] i_rd_addr_b,
    output logic      [DATA_W-1:0] o_rd_data_b,
    input  wire logic              i_wr_en,
    input  wire logic [REG_AW-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data
);

    localparam int NREG = 2**REG_AW;

    logic [DATA_W-1:0] r_mem [NREG];
    logic              w_wr;

    assign w_wr = i_wr_en && (i_wr_addr != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees stale data.
    always_comb begin
        o_rd_data_a = r_mem[i_rd_addr_a];
        if (i_rd_addr_a == '0) begin
            o_rd_data_a = '0;
        end else if (w_wr && (i_wr_addr == i_rd_addr_a)) begin
            o_rd_data_a = i_wr_data;
        end
    end

    always_comb begin
        o_rd_data_b = r_mem[i_rd_addr_b];
        if (i_rd_addr_b == '0) begin
            o_rd_data_b = '0;
        end else if (w_wr && (i_wr_addr == i_rd_addr_b)) begin
            o_rd_data_b = i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_issue_stage.sv
// ============================================================================
// id_issue_stage : decode, hazard scoreboard and registered issue slot to ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module id_issue_stage
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic     CLK,
    input  wire logic     RST_N,
    id_issue_stage_if.slave bus
);

    localparam int NREG = 2**REG_AW;

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_func;
    logic [15:0]       w_imm;
    decode_cls_e       w_cls;

    logic              w_use_rs;
    logic              w_use_rt;
    logic              w_has_dest;
    logic [REG_AW-1:0] w_dest_raw;
    logic              w_dest_en;

    logic [NREG-1:0]   r_sb;
    logic [NREG-1:0]   w_wb_clr;
    logic [NREG-1:0]   w_sb_set;
    logic [NREG-1:0]   w_busy;
    logic              w_stall;
    logic              w_slot_free;
    logic              w_if_ready;
    logic              w_accept;

    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    logic              r_ex_valid;
    logic [5:0]        r_opcode;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [4:0]        r_shamt;
    logic [5:0]        r_func;
    logic [15:0]       r_raw_val;
    logic              r_dest_en;
    logic [REG_AW-1:0] r_dest_addr;

    assign w_op    = bus.IF_INSTR[F_OP_HI:F_OP_LO];
    assign w_rs    = REG_AW'(bus.IF_INSTR[F_RS_HI:F_RS_LO]);
    assign w_rt    = REG_AW'(bus.IF_INSTR[F_RT_HI:F_RT_LO]);
    assign w_rd    = REG_AW'(bus.IF_INSTR[F_RD_HI:F_RD_LO]);
    assign w_shamt = bus.IF_INSTR[F_SH_HI:F_SH_LO];
    assign w_func  = bus.IF_INSTR[F_FN_HI:F_FN_LO];
    assign w_imm   = bus.IF_INSTR[F_IMM_HI:F_IMM_LO];
    assign w_cls   = decode_class(w_op);

    always_comb begin
        w_use_rs   = 1'b0;
        w_use_rt   = 1'b0;
        w_has_dest = 1'b0;
        w_dest_raw = w_rt;
        case (w_cls)
            CLS_R: begin
                w_use_rs   = 1'b1;
                w_use_rt   = 1'b1;
                w_has_dest = (w_func != FUNC_JR);
                w_dest_raw = w_rd;
            end
            CLS_IMM: begin
                w_use_rs   = 1'b1;
                w_has_dest = 1'b1;
            end
            CLS_LUI: begin
                w_has_dest = 1'b1;
            end
            CLS_STBR: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_dest_en = w_has_dest && (w_dest_raw != '0);

    always_comb begin
        w_wb_clr = '0;
        if (bus.WB_EN) begin
            w_wb_clr[bus.WB_ADDR] = 1'b1;
        end
    end

    always_comb begin
        w_sb_set = '0;
        if (w_accept && w_dest_en) begin
            w_sb_set[w_dest_raw] = 1'b1;
        end
    end

    // A register retiring this cycle is already readable through the bypass.
    assign w_busy = r_sb & ~w_wb_clr;

    assign w_stall = (w_use_rs  && w_busy[w_rs])
                  || (w_use_rt  && w_busy[w_rt])
                  || (w_dest_en && w_busy[w_dest_raw]);

    assign w_slot_free = !r_ex_valid || bus.EX_READY;
    assign w_if_ready  = bus.FLUSH || (w_slot_free && !w_stall);
    assign w_accept    = bus.IF_VALID && w_if_ready && !bus.FLUSH;

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .i_rd_addr_a (w_rs),
        .o_rd_data_a (w_rs_val),
        .i_rd_addr_b (w_rt),
        .o_rd_data_b (w_rt_val),
        .i_wr_en     (bus.WB_EN),
        .i_wr_addr   (bus.WB_ADDR),
        .i_wr_data   (bus.WB_DATA)
    );

    // Set after clear so a bypassed re-issue of the same dest stays pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_wb_clr) | w_sb_set;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ex_valid  <= 1'b0;
            r_opcode    <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_shamt     <= '0;
            r_func      <= '0;
            r_raw_val   <= '0;
            r_dest_en   <= 1'b0;
            r_dest_addr <= '0;
        end else if (w_accept) begin
            r_ex_valid  <= 1'b1;
            r_opcode    <= w_op;
            r_rs_val    <= w_rs_val;
            r_rt_val    <= w_rt_val;
            r_shamt     <= w_shamt;
            r_func      <= w_func;
            r_raw_val   <= w_imm;
            r_dest_en   <= w_dest_en;
            r_dest_addr <= w_dest_raw;
        end else if (bus.EX_READY) begin
            r_ex_valid  <= 1'b0;
        end
    end

    assign bus.IF_READY  = w_if_ready;
    assign bus.EX_VALID  = r_ex_valid;
    assign bus.OPCODE    = r_opcode;
    assign bus.RS_VAL    = r_rs_val;
    assign bus.RT_VAL    = r_rt_val;
    assign bus.SHAMT     = r_shamt;
    assign bus.FUNC      = r_func;
    assign bus.RAW_VAL   = r_raw_val;
    assign bus.DEST_EN   = r_dest_en;
    assign bus.DEST_ADDR = r_dest_addr;

endmodule

`default_nettype wire

// File: tb/tb_id_issue_stage.sv
// ============================================================================
// tb_id_issue_stage : directed + random stimulus, reference model and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_issue_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    id_issue_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] raw;
        logic        dest_en;
        logic [4:0]  dest;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view: which registers an instruction reads and writes.
    function automatic void m_decode(input logic [31:0] ins, output bit rd_rs,
                                     output bit rd_rt, output int dest);
        logic [5:0] op;
        op    = ins[31:26];
        rd_rs = 0;
        rd_rt = 0;
        dest  = -1;
        if (op == 6'h00) begin
            rd_rs = 1;
            rd_rt = 1;
            if (ins[5:0] != 6'h08) dest = int'(ins[15:11]);
        end else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23}) begin
            rd_rs = 1;
            dest  = int'(ins[20:16]);
        end else if (op == 6'h0F) begin
            dest = int'(ins[20:16]);
        end else if (op inside {6'h2B, 6'h04, 6'h05}) begin
            rd_rs = 1;
            rd_rt = 1;
        end
        if (dest == 0) dest = -1;
    endfunction

    function automatic bit m_is_busy(input int r, input bit we, input logic [4:0] wa);
        return (r != 0) && m_busy[r] && !(we && int'(wa) == r);
    endfunction

    function automatic logic [31:0] m_read(input int r, input bit we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && int'(wa) == r) return wd;
        return m_regs[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 0;
        end
        m_valid = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd);
        bit      u_rs, u_rt, stall, exp_rdy, acc;
        int      d, rs, rt;
        bundle_t b;
        @(negedge clk);
        bus.IF_VALID = v;
        bus.IF_INSTR = ins;
        bus.EX_READY = rdy;
        bus.FLUSH    = fl;
        bus.WB_EN    = we;
        bus.WB_ADDR  = wa;
        bus.WB_DATA  = wd;
        #1;
        m_decode(ins, u_rs, u_rt, d);
        rs      = int'(ins[25:21]);
        rt      = int'(ins[20:16]);
        stall   = (u_rs && m_is_busy(rs, we, wa)) || (u_rt && m_is_busy(rt, we, wa))
               || (d > 0 && m_is_busy(d, we, wa));
        exp_rdy = fl || ((!m_valid || rdy) && !stall);
        acc     = v && exp_rdy && !fl;
        chk("if_ready", {31'h0, bus.IF_READY}, {31'h0, exp_rdy});
        b.op      = ins[31:26];
        b.rs_val  = m_read(rs, we, wa, wd);
        b.rt_val  = m_read(rt, we, wa, wd);
        b.shamt   = ins[10:6];
        b.func    = ins[5:0];
        b.raw     = ins[15:0];
        b.dest_en = (d > 0);
        b.dest    = (d > 0) ? 5'(d) : ((ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16]);
        @(posedge clk);
        if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 0;
        end
        if (acc && d > 0) m_busy[d] = 1;
        if (acc) begin
            exp_q.push_back(b);
            m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 32'h0, rdy, 0, 0, 5'd0, 32'h0);
    endtask

    // Monitor: compare whatever the slot presents with the oldest expected bundle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("ex_valid", {31'h0, bus.EX_VALID}, {31'h0, m_valid});
                if (bus.EX_VALID && exp_q.size() > 0) begin
                    chk("opcode",    {26'h0, bus.OPCODE},    {26'h0, exp_q[0].op});
                    chk("rs_val",    bus.RS_VAL,             exp_q[0].rs_val);
                    chk("rt_val",    bus.RT_VAL,             exp_q[0].rt_val);
                    chk("shamt",     {27'h0, bus.SHAMT},     {27'h0, exp_q[0].shamt});
                    chk("func",      {26'h0, bus.FUNC},      {26'h0, exp_q[0].func});
                    chk("raw_val",   {16'h0, bus.RAW_VAL},   {16'h0, exp_q[0].raw});
                    chk("dest_en",   {31'h0, bus.DEST_EN},   {31'h0, exp_q[0].dest_en});
                    chk("dest_addr", {27'h0, bus.DEST_ADDR}, {27'h0, exp_q[0].dest});
                    if (bus.EX_READY) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic async_reset_mid();
        @(negedge clk);
        bus.IF_VALID = 0;
        bus.EX_READY = 0;
        bus.FLUSH    = 0;
        bus.WB_EN    = 0;
        #3;
        rst_n = 0;
        #1;
        chk("rst_async_ex_valid", {31'h0, bus.EX_VALID}, 32'h0);
        chk("rst_async_dest_en",  {31'h0, bus.DEST_EN},  32'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = int'($urandom_range(0, 12));
        case (k)
            0, 1, 2: w[31:26] = 6'h00;
            3:       w[31:26] = 6'h08;
            4:       w[31:26] = 6'h0A;
            5:       w[31:26] = 6'h0C;
            6:       w[31:26] = 6'h0D;
            7:       w[31:26] = 6'h23;
            8:       w[31:26] = 6'h0F;
            9:       w[31:26] = 6'h2B;
            10:      w[31:26] = ($urandom % 2 == 0) ? 6'h04 : 6'h05;
            default: w[31:26] = 6'($urandom);
        endcase
        w[25:21] = 5'($urandom % 8);
        w[20:16] = 5'($urandom % 8);
        w[15:11] = 5'($urandom % 8);
        if (w[31:26] == 6'h00 && $urandom % 5 == 0) w[5:0] = 6'h08;
        return w;
    endfunction

    initial begin
        bit          v, rdy, fl, we, found;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          st;

        bus.IF_VALID = 0;
        bus.IF_INSTR = 32'h0;
        bus.EX_READY = 0;
        bus.FLUSH    = 0;
        bus.WB_EN    = 0;
        bus.WB_ADDR  = 5'd0;
        bus.WB_DATA  = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ex_valid",  {31'h0, bus.EX_VALID},  32'h0);
        chk("reset_opcode",    {26'h0, bus.OPCODE},    32'h0);
        chk("reset_rs_val",    bus.RS_VAL,             32'h0);
        chk("reset_dest_addr", {27'h0, bus.DEST_ADDR}, 32'h0);
        rst_n = 1;

        // addi r1,r0,5 then RAW-dependent add r2,r1,r1
        step(1, 32'h20010005, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h00211020, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h00211020, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h00211020, 1, 0, 1, 5'd1, 32'd5);
        // backpressure with addi r8,r0,9 waiting
        repeat (3) step(1, 32'h20080009, 0, 0, 0, 5'd0, 32'h0);
        step(1, 32'h20080009, 1, 0, 0, 5'd0, 32'h0);
        // flushed ori r3,r0,7 then a use of r3
        step(1, 32'h34030007, 1, 1, 0, 5'd0, 32'h0);
        step(1, 32'h00634820, 1, 0, 0, 5'd0, 32'h0);
        // r0 rules
        step(0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(1, 32'h00002020, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h3C001234, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h00002820, 1, 0, 0, 5'd0, 32'h0);
        // hold a bundle with pending writes, then reset between edges
        step(1, 32'h20060001, 1, 0, 0, 5'd0, 32'h0);
        async_reset_mid();
        step(1, 32'h00223820, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h00C65020, 1, 0, 0, 5'd0, 32'h0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            v     = ($urandom % 4) != 0;
            rdy   = ($urandom % 10) < 7;
            fl    = ($urandom % 10) == 0;
            we    = 0;
            wa    = 5'd0;
            wd    = $urandom;
            found = 0;
            if ($urandom % 2 == 0) begin
                st = int'($urandom % 32);
                for (int k = 0; k < 32; k++) begin
                    if (!found && m_busy[(st + k) % 32]) begin
                        found = 1;
                        we    = 1;
                        wa    = 5'((st + k) % 32);
                    end
                end
            end
            if (!we && ($urandom % 8) == 0) begin
                we = 1;
                wa = 5'($urandom % 32);
            end
            step(v, rand_instr(), rdy, fl, we, wa, wd);
        end
        idle(1);
        idle(1);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts 32-bit MIPS-style instruction words from fetch and reads the 32x32 register file, which it owns.
- Tracks pending writes with a busy scoreboard and stalls on hazards.
- Drives the ALU operand bundle (OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL) from a registered valid/ready pipeline slot, and takes writeback from downstream.

Parameters:
- DATA_W, 32, register/operand width
- REG_AW, 5, register address width (2**REG_AW registers, r0 hardwired zero)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IF_VALID  in  1  instruction word valid
- IF_INSTR  in  32  instruction word
- IF_READY  out  1  stage accepts IF_INSTR this cycle
- EX_VALID  out  1  operand bundle valid
- EX_READY  in  1  ALU consumes bundle this cycle
- FLUSH  in  1  taken branch (ALU SIG_B qualified by EX handshake)
- OPCODE  out  6  instr[31:26]
- RS_VAL  out  DATA_W  register value of rs
- RT_VAL  out  DATA_W  register value of rt
- SHAMT  out  5  instr[10:6]
- FUNC  out  6  instr[5:0]
- RAW_VAL  out  16  instr[15:0]
- DEST_EN  out  1  bundle writes a register
- DEST_ADDR  out  REG_AW  destination register
- WB_EN  in  1  writeback strobe
- WB_ADDR  in  REG_AW  writeback register
- WB_DATA  in  DATA_W  writeback data

Behaviour:
- Reset (async, RST_N=0): all 32 registers = 0; scoreboard = 0; EX_VALID=0; OPCODE/RS_VAL/RT_VAL/SHAMT/FUNC/RAW_VAL/DEST_EN/DEST_ADDR=0.
- Reset mid-operation drops any held bundle; the first accept after reset is allowed in the first cycle after RST_N rises.
- Decode classes:
  - R-type (op 000000): reads rs, rt; dest = rd, except FUNC 001000 (jr), which has no dest.
  - ALU-imm (001000, 001010, 001100, 001101) and lw (100011): read rs; dest = rt.
  - lui (001111): no source; dest = rt.
  - sw (101011), beq (000100), bne (000101): read rs, rt; no dest.
  - Any other opcode: NOP class; no sources, no dest; fields still passed through.
  - Dest of r0 forces DEST_EN=0.
- Hazard rules:
  - busy(r) = scoreboard[r] && !(WB_EN && WB_ADDR==r).
  - stall = busy(any used source) || busy(dest when dest enabled).
  - The dest check blocks WAW, so at most one write per register is in flight.
  - r0 is never busy.
- Handshake:
  - slot_free = !EX_VALID || EX_READY.
  - IF_READY = FLUSH || (slot_free && !stall).
  - Accept = IF_VALID && IF_READY && !FLUSH.
  - On accept, the slot loads next cycle and EX_VALID=1; latency is 1 cycle and throughput is 1 instruction/cycle.
  - EX_VALID && EX_READY with no accept gives EX_VALID=0 next cycle.
  - Outputs hold stable while EX_VALID && !EX_READY.
- FLUSH: the instruction presented on IF in that cycle is consumed (IF_READY=1) and discarded, with no scoreboard change. The bundle in the slot is unaffected; it is the branch being resolved.
- Register read: value = WB_DATA when WB_EN && WB_ADDR==src && src!=0 (same-cycle bypass); otherwise the array value; r0 always reads 0.
- Writeback: WB_EN with WB_ADDR!=0 writes the array and clears scoreboard[WB_ADDR]. Writes to r0 are ignored.
- Simultaneous set and clear of the same bit (accept sets dest d, WB clears d): the set wins. The dest check normally prevents this; it remains legal only via bypass.
- No arithmetic in this block; RAW_VAL is passed unextended (the ALU extends).

Decomposition:
- Shared package `cpu_isa_pkg`:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE) and FUNC_JR
  - instruction field bit-range constants
  - decode-class enum {CLS_R, CLS_IMM, CLS_LUI, CLS_STBR, CLS_NOP}
- One sub-module, `id_regfile`: 2 combinational read ports with WB bypass, 1 write port, async-reset array, r0 hardwired.
- Scoreboard, decode and slot logic stay in `id_issue_stage`.

Test Plan:
- Reset: after reset, IF addi r1,r0,5 (0x20010005) with EX_READY=1 -> next cycle EX_VALID=1, OPCODE=001000, RS_VAL=0, RAW_VAL=0x0005, DEST_EN=1, DEST_ADDR=1; scoreboard[1]=1.
- RAW stall: then issue add r2,r1,r1 (0x00211020) -> IF_READY=0 until WB_EN=1, WB_ADDR=1, WB_DATA=5. In that WB cycle it is accepted; the next-cycle bundle has RS_VAL=5, RT_VAL=5, FUNC=100000, DEST_ADDR=2.
- Backpressure: EX_READY=0 for 3 cycles with a valid bundle -> IF_READY=0, outputs unchanged for all 3 cycles. EX_READY=1 -> the next instruction loads on the following edge.
- Flush: FLUSH=1 with IF_VALID=1 and instruction ori r3,r0,7 -> IF_READY=1; no bundle appears; scoreboard[3] stays 0.
- r0 rules: WB_EN=1, WB_ADDR=0, WB_DATA=0xFFFFFFFF, then add r4,r0,r0 -> RS_VAL=RT_VAL=0. A lui r0 gives DEST_EN=0 and no stall on a following use of r0.
- Async reset mid-stall: RST_N low between edges while a bundle is held and scoreboard bits are set -> EX_VALID=0 immediately; all scoreboard bits 0; register reads return 0.
